// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, cop0_sel encodings
// and the sequencer state type.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  // cop0_sel 2'b11 is reserved and decodes to nothing (NOP).
  localparam logic [1:0] SEL_MFC0 = 2'b00;
  localparam logic [1:0] SEL_MTC0 = 2'b01;
  localparam logic [1:0] SEL_ERET = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_GUARD   = 2'd2
  } cp0_state_t;

endpackage

// File: rtl/irq_pending.sv
// Interrupt front end: registered rising-edge detect, pending flops, mask gating
// and a fixed-priority (line 0 highest) one-hot grant.
module irq_pending
  import cp0_pkg::*;
#(
  parameter int NUM_IRQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] im,
  input  logic [NUM_IRQ-1:0] ack,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] grant,
  output logic               any_eligible
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_q2;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] elig;

  assign rise         = irq_q & ~irq_q2;
  assign elig         = pending & im;
  assign any_eligible = |elig;

  // A new rise wins over an ack landing on the same line in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      irq_q2  <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq_in;
      irq_q2  <= irq_q;
      pending <= (pending & ~ack) | rise;
    end
  end

  // Scan high to low so the lowest eligible index is the last one written.
  always_comb begin
    grant = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 exception/interrupt sequencer: syscall and IRQ entry, eret return, mfc0/mtc0.
// Optional IM mask bits are built when CP0_IRQ_MASK_EN is defined.
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ      = 3,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        pc_cur,
  input  logic               issyscall,
  input  logic               iscop0,
  input  logic [1:0]         cop0_sel,
  input  logic [4:0]         cop0_rd,
  input  logic [31:0]        cop0_wdata,
  output logic [31:0]        cop0_rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_service,
  output logic [1:0]         dbg_state
);

  cp0_state_t         state, state_n;
  logic               ie;
  logic [NUM_IRQ-1:0] im;
  logic [4:0]         exccode;
  logic [31:0]        epc;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] grant;
  logic               any_eligible;
  logic               take_sys;
  logic               take_int;
  logic               do_eret;
  logic               is_mfc0;
  logic               is_mtc0;
  logic               is_eret;

  assign is_mfc0 = iscop0 && (cop0_sel == SEL_MFC0);
  assign is_mtc0 = iscop0 && (cop0_sel == SEL_MTC0);
  assign is_eret = iscop0 && (cop0_sel == SEL_ERET);

`ifdef CP0_IRQ_MASK_EN
  logic [NUM_IRQ-1:0] im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q <= '1;
    end else if (is_mtc0 && (cop0_rd == CP0_STATUS)) begin
      im_q <= cop0_wdata[8 +: NUM_IRQ];
    end
  end

  assign im = im_q;
`else
  assign im = '1;
`endif

  irq_pending #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_pending (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .im           (im),
    .ack          (irq_ack),
    .pending      (pending),
    .grant        (grant),
    .any_eligible (any_eligible)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Entry and return are Mealy: the PC mux switches at the edge ending this cycle.
  always_comb begin
    state_n     = state;
    take_sys    = 1'b0;
    take_int    = 1'b0;
    do_eret     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    irq_ack     = '0;
    case (state)
      ST_IDLE: begin
        if (issyscall) begin
          take_sys = 1'b1;
          state_n  = ST_HANDLER;
        end else if (ie && any_eligible) begin
          take_int = 1'b1;
          state_n  = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (is_eret) begin
          do_eret = 1'b1;
          state_n = ST_GUARD;
        end
      end
      ST_GUARD: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (take_sys || take_int) begin
      redirect    = 1'b1;
      redirect_pc = HANDLER_ADDR;
    end else if (do_eret) begin
      redirect    = 1'b1;
      redirect_pc = epc;
    end
    if (take_int) begin
      irq_ack = grant;
    end
  end

  // Trap entry is written last so it overrides an mtc0 to EPC/Cause/IE in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie      <= 1'b1;
      exccode <= '0;
      epc     <= '0;
    end else begin
      if (is_mtc0 && (cop0_rd == CP0_STATUS)) begin
        ie <= cop0_wdata[0];
      end
      if (is_mtc0 && (cop0_rd == CP0_CAUSE)) begin
        exccode <= cop0_wdata[6:2];
      end
      if (is_mtc0 && (cop0_rd == CP0_EPC)) begin
        epc <= cop0_wdata;
      end
      if (take_sys) begin
        epc     <= pc_cur + 32'd4;
        exccode <= EXC_SYS;
        ie      <= 1'b0;
      end else if (take_int) begin
        epc     <= pc_cur;
        exccode <= EXC_INT;
        ie      <= 1'b0;
      end else if (do_eret) begin
        ie <= 1'b1;
      end
    end
  end

  // Read data is driven only for an actual mfc0 so the bus idles at zero.
  always_comb begin
    cop0_rdata = '0;
    if (is_mfc0) begin
      case (cop0_rd)
        CP0_STATUS: begin
          cop0_rdata[0]            = ie;
          cop0_rdata[8 +: NUM_IRQ] = im;
        end
        CP0_CAUSE: begin
          cop0_rdata[6:2]          = exccode;
          cop0_rdata[8 +: NUM_IRQ] = pending;
        end
        CP0_EPC: begin
          cop0_rdata = epc;
        end
        default: begin
          cop0_rdata = '0;
        end
      endcase
    end
  end

  assign in_service = (state == ST_HANDLER);
  assign dbg_state  = state;

endmodule
